ex_multicycle: RTL and testbench

Parametrised next-generation execute stage for the LEGv8 core.
- Keeps the single-cycle ALU ops, NZCV status register and branch-target adder.
- Adds iterative multiply and unsigned/signed divide under a valid/ready handshake, so the pipeline can stall on long-latency ops.
- Sits between ID and MEM; the pipeline controller stalls ID while in_ready=0.

---
 rtl/ex_multicycle.sv | 131 +++++++++++++
 tb/tb_ex_multicycle.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ex_multicycle.sv
// ex_multicycle: LEGv8 execute stage with single-cycle ALU, NZCV, branch adder, iterative MUL/DIV.
// Define EX_DIV_EN to build the restoring divider; otherwise UDIV/SDIV complete at once with op_err=1.
module ex_multicycle #(
  parameter int WIDTH    = 64,
  parameter int BR_SHIFT = 2,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] r_data1,
  input  logic [WIDTH-1:0] r_data2,
  input  logic [WIDTH-1:0] ex_data,
  input  logic             ALUSrc,
  input  logic             SregUp,
  input  logic [WIDTH-1:0] pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] ALU_res,
  output logic             op_err,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_q, b_q, acc_q, b_sel, b_add, fast_y, mul_acc, step_acc, step_a, mc_y;
  logic [WIDTH:0] sum;
  logic [CNT_W-1:0] cnt_q;
  logic sreg_q, sub, fast_c, fast_v;
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign b_sel     = ALUSrc ? ex_data : r_data2;
  assign sub       = op == 3'b011;
  assign b_add     = sub ? ~b_sel : b_sel;
  assign sum       = {1'b0, r_data1} + {1'b0, b_add} + {{WIDTH{1'b0}}, sub};
  assign fast_y    = op == 3'b000 ? r_data1 & b_sel :
                     op == 3'b001 ? r_data1 | b_sel :
                     op == 3'b111 ? b_sel :
                     op[2]        ? '0 : sum[WIDTH-1:0];
  assign fast_c    = op[2:1] == 2'b01 & sum[WIDTH];
  assign fast_v    = op[2:1] == 2'b01 & (r_data1[WIDTH-1] == b_add[WIDTH-1]) & (sum[WIDTH-1] != r_data1[WIDTH-1]);
`ifdef EX_DIV_EN
  logic neg_q;
  logic [WIDTH:0] rem_sh, diff;
  logic [WIDTH-1:0] q_nxt, a_mag, b_mag;
  assign rem_sh = {acc_q, a_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, b_q};
  assign q_nxt  = {a_q[WIDTH-2:0], ~diff[WIDTH]};
  assign a_mag  = (op == 3'b110 && r_data1[WIDTH-1]) ? -r_data1 : r_data1;
  assign b_mag  = (op == 3'b110 && b_sel[WIDTH-1]) ? -b_sel : b_sel;
`endif
  always_comb begin
    mul_acc  = acc_q + (b_q[0] ? a_q : '0);
    step_acc = mul_acc;
    step_a   = a_q << 1;
    mc_y     = mul_acc;
`ifdef EX_DIV_EN
    if (state == S_DIV) begin
      step_acc = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      step_a   = q_nxt;
      mc_y     = ~|b_q ? '0 : neg_q ? -q_nxt : q_nxt;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sreg_q  <= 1'b0;
      ALUOut  <= '0;
      ALU_res <= '0;
      op_err  <= 1'b0;
      {N, Z, C, V} <= 4'b0000;
`ifdef EX_DIV_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_q     <= r_data1;
          b_q     <= b_sel;
          acc_q   <= '0;
          cnt_q   <= '0;
          sreg_q  <= SregUp;
          ALU_res <= pc + (ex_data << BR_SHIFT);
          op_err  <= 1'b0;
          if (op == 3'b100) state <= S_MUL;
`ifdef EX_DIV_EN
          else if (op == 3'b101 || op == 3'b110) begin
            a_q   <= a_mag;
            b_q   <= b_mag;
            neg_q <= op == 3'b110 && (r_data1[WIDTH-1] ^ b_sel[WIDTH-1]);
            state <= S_DIV;
          end
`else
          else if (op == 3'b101 || op == 3'b110) begin
            ALUOut <= '0;
            op_err <= 1'b1;
            state  <= S_DONE;
          end
`endif
          else begin
            ALUOut <= fast_y;
            if (SregUp) {N, Z, C, V} <= {fast_y[WIDTH-1], ~|fast_y, fast_c, fast_v};
            state  <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: begin
          acc_q <= step_acc;
          a_q   <= step_a;
          b_q   <= state == S_MUL ? b_q >> 1 : b_q;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            ALUOut <= mc_y;
            if (sreg_q) {N, Z, C, V} <= {mc_y[WIDTH-1], ~|mc_y, 2'b00};
            state  <= S_DONE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_multicycle.sv
// tb_ex_multicycle: directed vectors with hand-computed results for ex_multicycle (WIDTH=64).
module tb_ex_multicycle;
  localparam logic [2:0] AND_OP = 3'b000, ORR_OP = 3'b001, ADD_OP = 3'b010, SUB_OP = 3'b011,
                         MUL_OP = 3'b100, UDIV_OP = 3'b101, SDIV_OP = 3'b110, PASSB_OP = 3'b111;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, ALUSrc = 0, SregUp = 0;
  logic out_valid, out_ready = 0, op_err, N, Z, C, V;
  logic [2:0] op = '0;
  logic [63:0] r_data1 = '0, r_data2 = '0, ex_data = '0, pc = '0, ALUOut, ALU_res, held;
  int checks = 0, errors = 0, lat, seen;
  ex_multicycle dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .r_data1(r_data1), .r_data2(r_data2), .ex_data(ex_data), .ALUSrc(ALUSrc), .SregUp(SregUp), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .ALUOut(ALUOut), .ALU_res(ALU_res), .op_err(op_err),
    .N(N), .Z(Z), .C(C), .V(V));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input logic [63:0] e,
                      input logic src, input logic sreg, input logic [63:0] p);
    op = o; r_data1 = a; r_data2 = b; ex_data = e; ALUSrc = src; SregUp = sreg; pc = p; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
  endtask
  task automatic wait_done(output int l);
    l = 1;
    while (!out_valid && l < 200) begin
      @(posedge clk); #1 l++;
    end
  endtask
  task automatic pop;
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
  endtask
  initial begin
    #12;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_aluout", ALUOut, 0);
    check("rst_alu_res", ALU_res, 0);
    check("rst_flags", 64'({N, Z, C, V, op_err}), 0);
    @(posedge clk); #1 rst_n = 1;
    check("rst_in_ready", 64'(in_ready), 1);
    send(ADD_OP, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 1, 64'd0);
    wait_done(lat);
    check("add_lat", 64'(lat), 1);
    check("add_in_ready", 64'(in_ready), 0);
    check("add_res", ALUOut, MIN);
    check("add_nzcv", 64'({N, Z, C, V}), 64'b1001);
    pop();
    send(SUB_OP, 64'd5, 64'd99, 64'd5, 1, 1, 64'h100);
    wait_done(lat);
    check("sub_lat", 64'(lat), 1);
    check("sub_res", ALUOut, 0);
    check("sub_nzcv", 64'({N, Z, C, V}), 64'b0110);
    check("sub_br", ALU_res, 64'h114);
    pop();
    send(AND_OP, MIN | 64'hF, MIN | 64'h3, 64'd0, 0, 1, 64'd0);
    wait_done(lat);
    check("and_res", ALUOut, MIN | 64'h3);
    check("and_nzcv", 64'({N, Z, C, V}), 64'b1000);
    pop();
    send(ADD_OP, 64'd0, 64'd0, 64'd0, 0, 0, 64'd0);
    wait_done(lat);
    check("nosreg_res", ALUOut, 0);
    check("nosreg_nzcv", 64'({N, Z, C, V}), 64'b1000);
    pop();
    send(ORR_OP, 64'hF0, 64'h0F, 64'd0, 0, 1, 64'd0);
    wait_done(lat);
    check("orr_res", ALUOut, 64'hFF);
    check("orr_nzcv", 64'({N, Z, C, V}), 64'b0000);
    pop();
    send(PASSB_OP, 64'h1234, 64'd7, 64'hDEAD, 1, 0, 64'd0);
    wait_done(lat);
    check("passb_res", ALUOut, 64'hDEAD);
    pop();
    send(MUL_OP, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 64'h200);
    check("mul_busy", 64'(in_ready), 0);
    wait_done(lat);
    check("mul_lat", 64'(lat), 65);
    check("mul_res", ALUOut, 64'hFFFF_FFFF_FFFF_FFFD);
    check("mul_nzcv", 64'({N, Z, C, V}), 64'b1000);
    check("mul_br", ALU_res, 64'h1FC);
    held = ALUOut;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mul_hold_valid", 64'(out_valid), 1);
      check("mul_hold_res", ALUOut, held);
    end
    pop();
    check("mul_pop", 64'(in_ready), 1);
`ifdef EX_DIV_EN
    send(SDIV_OP, -64'sd7, 64'd2, 64'd0, 0, 1, 64'd0);
    wait_done(lat);
    check("sdiv_lat", 64'(lat), 65);
    check("sdiv_res", ALUOut, 64'hFFFF_FFFF_FFFF_FFFD);
    check("sdiv_nzcv", 64'({N, Z, C, V}), 64'b1000);
    check("sdiv_err", 64'(op_err), 0);
    pop();
    send(UDIV_OP, 64'd100, 64'd0, 64'd0, 0, 1, 64'd0);
    wait_done(lat);
    check("udiv0_lat", 64'(lat), 65);
    check("udiv0_res", ALUOut, 0);
    check("udiv0_nzcv", 64'({N, Z, C, V}), 64'b0100);
    pop();
    send(UDIV_OP, 64'd100, 64'd7, 64'd0, 0, 0, 64'd0);
    wait_done(lat);
    check("udiv_res", ALUOut, 64'd14);
    pop();
    send(SDIV_OP, MIN, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 64'd0);
    wait_done(lat);
    check("sdiv_min_lat", 64'(lat), 65);
    check("sdiv_min_res", ALUOut, MIN);
    pop();
`else
    send(UDIV_OP, 64'd100, 64'd7, 64'd0, 0, 1, 64'd0);
    wait_done(lat);
    check("nodiv_lat", 64'(lat), 1);
    check("nodiv_res", ALUOut, 0);
    check("nodiv_err", 64'(op_err), 1);
    check("nodiv_nzcv", 64'({N, Z, C, V}), 64'b1000);
    pop();
    send(ADD_OP, 64'd2, 64'd3, 64'd0, 0, 0, 64'd0);
    wait_done(lat);
    check("err_clear", 64'(op_err), 0);
    check("err_clear_res", ALUOut, 64'd5);
    pop();
`endif
    send(MUL_OP, 64'd6, 64'd7, 64'd1, 0, 1, 64'd0);
    repeat (29) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("abort_out_valid", 64'(out_valid), 0);
    check("abort_res", ALUOut, 0);
    check("abort_br", ALU_res, 0);
    check("abort_flags", 64'({N, Z, C, V, op_err}), 0);
    @(posedge clk); #1 rst_n = 1;
    check("abort_in_ready", 64'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_pulse", 64'(seen), 0);
    send(ADD_OP, 64'd40, 64'd2, 64'd0, 0, 1, 64'd0);
    wait_done(lat);
    check("post_rst_res", ALUOut, 64'd42);
    pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
